// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared constants and types for the register file writeback arbiter
package rf_wb_arbiter_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_ZERO_REG = 0;

    typedef enum logic {
        NORMAL  = 1'b0,
        FORCE_B = 1'b1
    } wb_arb_state_t;

endpackage

// File: rtl/rf_wb_outreg.sv
// rtl/rf_wb_outreg.sv - registered register-file write port with register-zero suppression
module rf_wb_outreg
    import rf_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_REG);

    // Address/data follow every accepted write; only the enable is masked for r0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we <= wr_en && (wr_addr != ZERO_ADDR);
            if (wr_en) begin
                waddr <= wr_addr;
                wdata <= wr_data;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-requester writeback arbiter, fixed priority to A with starvation guard for B
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W     = RF_ADDR_W,
    parameter int DATA_W     = RF_DATA_W,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              forced
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    wb_arb_state_t state, state_nxt;
    logic [3:0]    starve_cnt, cnt_nxt;
    logic          a_acc, b_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= NORMAL;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= cnt_nxt;
        end
    end

    assign a_acc = a_valid && a_ready;
    assign b_acc = b_valid && b_ready;

    always_comb begin
        cnt_nxt = 4'd0;
        if (b_valid && !b_acc)
            cnt_nxt = (starve_cnt >= SMAX) ? SMAX : starve_cnt + 4'd1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            NORMAL:  if (cnt_nxt == SMAX) state_nxt = FORCE_B;
            FORCE_B: if (b_acc || !b_valid) state_nxt = NORMAL;
            default: state_nxt = NORMAL;
        endcase
    end

    // Readies depend only on state and a_valid so B can never create a combinational loop.
    always_comb begin
        a_ready = 1'b1;
        b_ready = ~a_valid;
        forced  = 1'b0;
        if (state == FORCE_B) begin
            a_ready = 1'b0;
            b_ready = 1'b1;
            forced  = 1'b1;
        end
    end

    rf_wb_outreg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_outreg (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (a_acc || b_acc),
        .wr_addr (a_acc ? a_addr : b_addr),
        .wr_data (a_acc ? a_data : b_data),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - randomized and directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        av[2], bv[2];
    logic [4:0]  aa[2], ba[2];
    logic [31:0] ad[2], bd[2];
    logic        ar[2], br[2], we[2], fo[2];
    logic [4:0]  wa[2];
    logic [31:0] wd[2];

    int          checks = 0;
    int          errors = 0;

    int          mx[2] = '{3, 1};
    int          lost[2];
    logic        exp_we[2];
    logic [4:0]  exp_wa[2];
    logic [31:0] exp_wd[2];
    logic [31:0] rf[2][32];
    logic        last_aacc[2], last_bacc[2], s_forced[2], s_ar[2];

    always #5 clk = ~clk;

    rf_wb_arbiter #(.STARVE_MAX(3)) dut0 (
        .clk(clk), .rst(rst),
        .a_valid(av[0]), .a_ready(ar[0]), .a_addr(aa[0]), .a_data(ad[0]),
        .b_valid(bv[0]), .b_ready(br[0]), .b_addr(ba[0]), .b_data(bd[0]),
        .rf_we(we[0]), .rf_waddr(wa[0]), .rf_wdata(wd[0]), .forced(fo[0])
    );

    rf_wb_arbiter #(.STARVE_MAX(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_valid(av[1]), .a_ready(ar[1]), .a_addr(aa[1]), .a_data(ad[1]),
        .b_valid(bv[1]), .b_ready(br[1]), .b_addr(ba[1]), .b_data(bd[1]),
        .rf_we(we[1]), .rf_waddr(wa[1]), .rf_wdata(wd[1]), .forced(fo[1])
    );

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            lost[i] = 0;
            exp_we[i] = 1'b0;
            exp_wa[i] = '0;
            exp_wd[i] = '0;
            last_aacc[i] = 1'b0;
            last_bacc[i] = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            av[i] = 1'b0; bv[i] = 1'b0;
            aa[i] = '0; ba[i] = '0; ad[i] = '0; bd[i] = '0;
        end
    endtask

    // One clock: inputs are already set at the falling edge; returns at the next falling edge.
    task automatic cycle();
        logic aacc[2], bacc[2], mf;
        #2;
        for (int i = 0; i < 2; i++) begin
            mf = (lost[i] == mx[i]);
            check("a_ready", i, 32'(ar[i]), 32'(!mf));
            check("b_ready", i, 32'(br[i]), 32'(mf || !av[i]));
            check("forced", i, 32'(fo[i]), 32'(mf));
            s_forced[i] = fo[i];
            s_ar[i] = ar[i];
            aacc[i] = av[i] && !mf;
            bacc[i] = bv[i] && (mf || !av[i]);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            lost[i] = (bv[i] && !bacc[i]) ? ((lost[i] + 1 > mx[i]) ? mx[i] : lost[i] + 1) : 0;
            exp_we[i] = 1'b0;
            if (aacc[i]) begin
                exp_we[i] = (aa[i] != 0); exp_wa[i] = aa[i]; exp_wd[i] = ad[i];
            end else if (bacc[i]) begin
                exp_we[i] = (ba[i] != 0); exp_wa[i] = ba[i]; exp_wd[i] = bd[i];
            end
            if (exp_we[i]) rf[i][exp_wa[i]] = exp_wd[i];
            check("rf_we", i, 32'(we[i]), 32'(exp_we[i]));
            check("rf_waddr", i, 32'(wa[i]), 32'(exp_wa[i]));
            check("rf_wdata", i, wd[i], exp_wd[i]);
            last_aacc[i] = aacc[i];
            last_bacc[i] = bacc[i];
        end
        @(negedge clk);
    endtask

    initial begin
        logic [4:0] seq[5];
        idle_inputs();
        model_reset();
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 32; r++) rf[i][r] = '0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_we", i, 32'(we[i]), 32'h0);
            check("reset_waddr", i, 32'(wa[i]), 32'h0);
            check("reset_wdata", i, wd[i], 32'h0);
            check("reset_forced", i, 32'(fo[i]), 32'h0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // A only
        av[0] = 1'b1; aa[0] = 5'd5; ad[0] = 32'hDEADBEEF;
        cycle();
        check("aonly_ready", 0, 32'(s_ar[0]), 32'h1);
        check("aonly_we", 0, 32'(we[0]), 32'h1);
        check("aonly_waddr", 0, 32'(wa[0]), 32'h5);
        check("aonly_wdata", 0, wd[0], 32'hDEADBEEF);
        idle_inputs();
        cycle();
        check("aonly_we_after", 0, 32'(we[0]), 32'h0);

        // B only
        bv[0] = 1'b1; ba[0] = 5'd9; bd[0] = 32'h12345678;
        cycle();
        check("bonly_waddr", 0, 32'(wa[0]), 32'h9);
        check("bonly_wdata", 0, wd[0], 32'h12345678);
        idle_inputs();
        cycle();

        // Zero register
        av[0] = 1'b1; aa[0] = 5'd0; ad[0] = 32'hFFFFFFFF;
        cycle();
        check("zero_ready", 0, 32'(s_ar[0]), 32'h1);
        check("zero_we", 0, 32'(we[0]), 32'h0);

        // Reset mid-operation with a write presented
        aa[0] = 5'd4; ad[0] = 32'hA5A5A5A5;
        cycle();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_we", 0, 32'(we[0]), 32'h0);
        check("midrst_waddr", 0, 32'(wa[0]), 32'h0);
        check("midrst_wdata", 0, wd[0], 32'h0);
        check("midrst_forced", 0, 32'(fo[0]), 32'h0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        av[0] = 1'b1; aa[0] = 5'd6; ad[0] = 32'h00000055;
        cycle();
        check("postrst_wdata", 0, wd[0], 32'h00000055);
        idle_inputs();
        cycle();

        // Starvation with STARVE_MAX=3
        av[0] = 1'b1; aa[0] = 5'd1; ad[0] = 32'h11;
        bv[0] = 1'b1; ba[0] = 5'd2; bd[0] = 32'h22;
        for (int k = 0; k < 5; k++) begin
            cycle();
            seq[k] = wa[0];
            if (k == 3) check("starve_forced", 0, 32'(s_forced[0]), 32'h1);
        end
        check("starve_seq0", 0, 32'(seq[0]), 32'h1);
        check("starve_seq1", 0, 32'(seq[1]), 32'h1);
        check("starve_seq2", 0, 32'(seq[2]), 32'h1);
        check("starve_seq3", 0, 32'(seq[3]), 32'h2);
        check("starve_seq4", 0, 32'(seq[4]), 32'h1);
        idle_inputs();
        cycle();

        // Collision on r7 with STARVE_MAX=1
        av[1] = 1'b1; aa[1] = 5'd7; ad[1] = 32'h1;
        bv[1] = 1'b1; ba[1] = 5'd7; bd[1] = 32'h2;
        cycle();
        check("coll_first", 1, wd[1], 32'h1);
        av[1] = 1'b0;
        cycle();
        check("coll_forced", 1, 32'(s_forced[1]), 32'h1);
        check("coll_second", 1, wd[1], 32'h2);
        check("coll_r7", 1, rf[1][7], 32'h2);
        idle_inputs();
        cycle();

        // B withdraws while forced
        av[1] = 1'b1; aa[1] = 5'd3; ad[1] = 32'h33;
        bv[1] = 1'b1; ba[1] = 5'd8; bd[1] = 32'h44;
        cycle();
        bv[1] = 1'b0;
        aa[1] = 5'd10;
        cycle();
        check("withdraw_forced", 1, 32'(s_forced[1]), 32'h1);
        cycle();
        check("withdraw_normal", 1, 32'(s_forced[1]), 32'h0);
        check("withdraw_aready", 1, 32'(s_ar[1]), 32'h1);
        idle_inputs();
        cycle();

        // Randomized traffic with hold-until-accepted requesters
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!av[i] || last_aacc[i]) begin
                    av[i] = ($urandom_range(0, 3) != 0);
                    aa[i] = 5'($urandom_range(0, 31));
                    ad[i] = $urandom;
                end
                if (!bv[i] || last_bacc[i] || $urandom_range(0, 15) == 0) begin
                    bv[i] = ($urandom_range(0, 2) != 0);
                    ba[i] = 5'($urandom_range(0, 31));
                    bd[i] = $urandom;
                end
                last_aacc[i] = 1'b0;
                last_bacc[i] = 1'b0;
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Arbitrates the register file's single write port between two writeback requesters.
- Requester A is the main datapath writeback: ALU/load result, destination already resolved by the RegDst selection.
- Requester B is the multi-cycle multiply/divide unit returning results late.
- Has a registered output stage, fixed priority to A, and a starvation guard that forces a B grant after STARVE_MAX consecutive lost cycles.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, write data width.
- STARVE_MAX, 3, consecutive cycles B may be refused before a forced grant (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- a_valid  input  1  requester A has a write pending.
- a_ready  output  1  A's write accepted this cycle when a_valid and a_ready are both high.
- a_addr  input  ADDR_W  A destination register.
- a_data  input  DATA_W  A write data.
- b_valid  input  1  requester B has a write pending.
- b_ready  output  1  B's write accepted this cycle when b_valid and b_ready are both high.
- b_addr  input  ADDR_W  B destination register.
- b_data  input  DATA_W  B write data.
- rf_we  output  1  register file write enable, registered.
- rf_waddr  output  ADDR_W  register file write address, registered.
- rf_wdata  output  DATA_W  register file write data, registered.
- forced  output  1  high in cycles where state is FORCE_B (debug/perf).

Behaviour:
- Reset (async, rst=1): rf_we=0, rf_waddr=0, rf_wdata=0, starve_cnt=0, state=NORMAL, forced=0. Outputs stay at these values while rst is high.
- Reset mid-operation: any accepted write not yet presented is dropped. The requester must reissue it.
- FSM states:
  - NORMAL: a_ready=1; b_ready = ~a_valid.
  - FORCE_B: a_ready=0; b_ready=1; forced=1.
- Ready outputs are combinational from state and a_valid only. They never depend on b_valid.
- At most one acceptance per cycle.
- starve_cnt (4 bits) updates:
  - Increments when b_valid=1 and B is not accepted; saturates at STARVE_MAX.
  - Clears to 0 when B is accepted or b_valid=0.
- Transitions:
  - NORMAL -> FORCE_B when the next starve_cnt equals STARVE_MAX.
  - FORCE_B -> NORMAL when B is accepted, or when b_valid drops (requester withdrew; counter cleared).
- Output stage: on acceptance of X, next cycle rf_we=1, rf_waddr=X_addr, rf_wdata=X_data. With no acceptance, next cycle rf_we=0 and addr/data hold their previous values. Latency is exactly 1 cycle.
- Register 0 is hardwired zero. An accepted write with addr==0 completes the handshake but yields rf_we=0 the next cycle.
- Same-address collision (both valid, same addr): order equals grant order. The later-granted write lands later and wins in the register file. There is no merging.
- Requesters must hold valid/addr/data stable until accepted. The block does not check this.
- B is never starved beyond STARVE_MAX+1 cycles. A stalls at most 1 cycle per forced grant.

Decomposition:
- Shared package holds:
  - Constants RF_ADDR_W=5, RF_DATA_W=32, RF_ZERO_REG=0.
  - Enum wb_arb_state_t {NORMAL, FORCE_B}.
- One natural sub-module, rf_wb_outreg: a registered write-port stage with async reset and zero-register suppression. It is reusable by any future write-port source.
- FSM and starvation counter stay in the top module.

Test Plan:
- Reset: assert rst mid-cycle with a write in flight -> rf_we=0, rf_waddr=0, rf_wdata=0, forced=0 immediately. After deassert, the first accepted write appears exactly 1 cycle later.
- A only: a_valid=1, a_addr=5, a_data=0xDEADBEEF for 1 cycle -> a_ready=1. Next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF. The following cycle rf_we=0.
- B only: b_valid=1, b_addr=9, b_data=0x12345678 with a_valid=0 -> b_ready=1 and the write lands 1 cycle later. starve_cnt stays 0.
- Starvation, STARVE_MAX=3: a_valid and b_valid held high continuously ->
  - A is accepted in cycles 0-2.
  - Cycle 3: forced=1, a_ready=0, B is accepted.
  - Cycle 4: A resumes.
  - rf_waddr sequence is A,A,A,B,A.
- Zero register: a_valid=1, a_addr=0, a_data=0xFFFFFFFF -> a_ready=1 and rf_we stays 0 the next cycle.
- Collision: both valid, addr=7, A data=0x1, B data=0x2, STARVE_MAX=1 ->
  - Cycle 0 grants A; cycle 1 grants B (forced).
  - rf_wdata is 0x1 then 0x2, so the final r7 value is 0x2.
  - B withdrawing in FORCE_B returns state to NORMAL.
